serial_addsub_10: RTL and testbench

Bit-serial 10-bit two's-complement adder/subtractor. Computes A+B or A−B (A + ~B + 1, carry-in of one). Sits directly downstream of the combinational negation stage in the datapath and is its multi-cycle, low-area replacement. It processes one bit per clock through a single full-adder cell and reports the result with carry-out and signed-overflow flags.

---
 rtl/serial_addsub_10_pkg.sv | 17 +
 rtl/serial_addsub_10_if.sv | 27 ++
 rtl/serial_addsub_10_fa.sv | 13 +
 rtl/serial_addsub_10.sv | 123 ++++++++++++
 tb/tb_serial_addsub_10.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/serial_addsub_10_pkg.sv
// Shared types and sizing for the bit-serial 10-bit adder/subtractor.
package serial_addsub_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_e;

   localparam int DEFAULT_WIDTH = 10;

   // Bit counter must be able to represent 0..WIDTH.
   function automatic int cnt_width(input int w);
      return $clog2(w + 1);
   endfunction

endpackage

// File: rtl/serial_addsub_10_if.sv
// Request/response bundle between the negation stage and the serial add/sub unit.
interface serial_addsub_10_if
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             start;
   logic             sub;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             busy;
   logic             done;
   logic [WIDTH-1:0] S;
   logic             Co;
   logic             V;

   modport master (
      output start, sub, A, B,
      input  busy, done, S, Co, V
   );

   modport slave (
      input  start, sub, A, B,
      output busy, done, S, Co, V
   );

endinterface

// File: rtl/serial_addsub_10_fa.sv
// Single full-adder cell; the only arithmetic in the serial datapath.
module full_adder_1 (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub_10.sv
// Bit-serial two's-complement add/subtract, LSB first, one bit per clock.
module serial_addsub_10
   import serial_addsub_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic               clk,
   input  logic               reset_n,
   serial_addsub_10_if.slave  bus
);

   localparam int CNT_W = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   a_sr_q, a_sr_d;
   logic [WIDTH-1:0]   b_sr_q, b_sr_d;
   logic [WIDTH-1:0]   res_sr_q, res_sr_d;
   logic [CNT_W-1:0]   count_q, count_d;
   logic               carry_q, carry_d;
   logic               c_msb_q, c_msb_d;
   logic [WIDTH-1:0]   s_q, s_d;
   logic               co_q, co_d;
   logic               v_q, v_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;

   logic               fa_s, fa_co;

   full_adder_1 u_fa (
      .a  (a_sr_q[0]),
      .b  (b_sr_q[0]),
      .ci (carry_q),
      .s  (fa_s),
      .co (fa_co)
   );

   always_comb begin
      state_d  = state_q;
      a_sr_d   = a_sr_q;
      b_sr_d   = b_sr_q;
      res_sr_d = res_sr_q;
      count_d  = count_q;
      carry_d  = carry_q;
      c_msb_d  = c_msb_q;
      s_d      = s_q;
      co_d     = co_q;
      v_d      = v_q;
      busy_d   = 1'b0;
      done_d   = 1'b0;

      unique case (state_q)
         IDLE, DONE: begin
            state_d = IDLE;
            if (bus.start) begin
               // Subtract is A + ~B + 1: invert B here, inject the +1 as carry-in.
               state_d = SHIFT;
               a_sr_d  = bus.A;
               b_sr_d  = bus.B ^ {WIDTH{bus.sub}};
               carry_d = bus.sub;
               count_d = '0;
               busy_d  = 1'b1;
            end
         end
         SHIFT: begin
            a_sr_d   = a_sr_q >> 1;
            b_sr_d   = b_sr_q >> 1;
            res_sr_d = {fa_s, res_sr_q[WIDTH-1:1]};
            carry_d  = fa_co;
            count_d  = count_q + CNT_W'(1);
            busy_d   = 1'b1;
            if (count_q == LAST_BIT) begin
               // Publish on the edge into DONE so results appear with the done pulse.
               state_d = DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               c_msb_d = carry_q;
               s_d     = {fa_s, res_sr_q[WIDTH-1:1]};
               co_d    = fa_co;
               v_d     = carry_q ^ fa_co;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= IDLE;
         a_sr_q   <= '0;
         b_sr_q   <= '0;
         res_sr_q <= '0;
         count_q  <= '0;
         carry_q  <= 1'b0;
         c_msb_q  <= 1'b0;
         s_q      <= '0;
         co_q     <= 1'b0;
         v_q      <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         a_sr_q   <= a_sr_d;
         b_sr_q   <= b_sr_d;
         res_sr_q <= res_sr_d;
         count_q  <= count_d;
         carry_q  <= carry_d;
         c_msb_q  <= c_msb_d;
         s_q      <= s_d;
         co_q     <= co_d;
         v_q      <= v_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.S    = s_q;
   assign bus.Co   = co_q;
   assign bus.V    = v_q;

endmodule

// File: tb/tb_serial_addsub_10.sv
// Scoreboard bench: stimulus pushes model results, a negedge monitor checks each done pulse.
module tb_serial_addsub_10;

   localparam int W   = 10;
   localparam int LAT = W + 1;

   typedef struct {
      logic [W-1:0] s;
      logic         co;
      logic         v;
      int           done_cyc;
   } exp_t;

   logic clk;
   logic rst_n;
   int   cyc;
   int   tests;
   int   fails;
   exp_t sb[$];

   serial_addsub_10_if #(.WIDTH(W)) bus ();

   serial_addsub_10 #(.WIDTH(W)) dut (
      .clk     (clk),
      .reset_n (rst_n),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Reference: plain integer arithmetic on unsigned and signed views of the operands.
   function automatic exp_t model(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b);
      exp_t e;
      int ua, ub, sa, sb_, u, r;
      ua = int'(a);
      ub = int'(b);
      sa = a[W-1] ? ua - (1 << W) : ua;
      sb_ = b[W-1] ? ub - (1 << W) : ub;
      u = sub ? ua - ub : ua + ub;
      r = sub ? sa - sb_ : sa + sb_;
      e.s  = W'((u + (1 << W)) % (1 << W));
      e.co = sub ? (ua >= ub) : (u >= (1 << W));
      e.v  = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
      e.done_cyc = 0;
      return e;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b, output int c0);
      exp_t e;
      e = model(sub, a, b);
      c0 = cyc;
      e.done_cyc = c0 + LAT;
      sb.push_back(e);
      bus.start = 1'b1;
      bus.sub   = sub;
      bus.A     = a;
      bus.B     = b;
      step();
      bus.start = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (bus.busy === 1'b1 && n < 40) begin
         step();
         n++;
      end
      if (bus.busy !== 1'b0) chk("busy_timeout", 32'(bus.busy), 32'd0);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 100) begin
         step();
         n++;
      end
      if (sb.size() > 0) chk("drain_timeout", 32'(sb.size()), 32'd0);
   endtask

   // Monitor: every done pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst_n && bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            chk("spurious_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("result_S",  32'(bus.S),  32'(e.s));
            chk("result_Co", 32'(bus.Co), 32'(e.co));
            chk("result_V",  32'(bus.V),  32'(e.v));
            chk("done_cycle", 32'(cyc), 32'(e.done_cyc));
         end
      end
   end

   initial begin
      int c0, c1, gap;
      exp_t ref1;
      cyc = 0; tests = 0; fails = 0;
      rst_n = 1'b0;
      bus.start = 1'b0; bus.sub = 1'b0; bus.A = '0; bus.B = '0;
      repeat (3) step();
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_done", 32'(bus.done), 32'd0);
      chk("rst_S",    32'(bus.S),    32'd0);
      chk("rst_CoV",  32'({bus.Co, bus.V}), 32'd0);
      rst_n = 1'b1;
      step();

      // Add with exact busy/done window
      issue(1'b0, 10'd3, 10'd5, c0);
      for (int k = 1; k <= LAT; k++) begin
         chk("busy_window", 32'(bus.busy), 32'(k <= W));
         chk("done_window", 32'(bus.done), 32'(k == LAT));
         if (k < LAT) step();
      end
      step();
      drain();

      // Directed subtract / overflow corners
      wait_idle(); issue(1'b1, 10'd5,   10'd3,   c0); drain();
      wait_idle(); issue(1'b1, 10'd0,   10'd1,   c0); drain();
      wait_idle(); issue(1'b0, 10'h1FF, 10'h001, c0); drain();
      wait_idle(); issue(1'b1, 10'h000, 10'h200, c0); drain();
      wait_idle(); issue(1'b0, 10'h3FF, 10'h3FF, c0); drain();

      // Start while busy must be ignored
      wait_idle();
      issue(1'b0, 10'h0F0, 10'h00F, c0);
      repeat (3) step();
      bus.start = 1'b1; bus.sub = 1'b1; bus.A = 10'h3FF; bus.B = 10'h123;
      step();
      bus.start = 1'b0;
      drain();
      repeat (3) step();

      // Back-to-back: second start in the first op's done cycle
      issue(1'b0, 10'd3, 10'd5, c0);
      ref1 = model(1'b0, 10'd3, 10'd5);
      while (cyc < c0 + LAT) step();
      chk("b2b_done_level", 32'(bus.done), 32'd1);
      issue(1'b0, 10'h100, 10'h001, c1);
      while (cyc < c0 + 2 * LAT) begin
         chk("b2b_S_hold", 32'(bus.S), 32'(ref1.s));
         step();
      end
      drain();

      // Reset mid-operation discards the in-flight result
      wait_idle();
      issue(1'b0, 10'h055, 10'h0AA, c0);
      while (cyc < c0 + 5) step();
      rst_n = 1'b0;
      void'(sb.pop_back());
      #1;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_S",    32'(bus.S),    32'd0);
      chk("midrst_CoV",  32'({bus.Co, bus.V, bus.done}), 32'd0);
      repeat (2) step();
      rst_n = 1'b1;
      repeat (14) begin
         chk("midrst_no_done", 32'(bus.done), 32'd0);
         step();
      end
      issue(1'b1, 10'd7, 10'd2, c0);
      drain();

      // Randomized traffic, gaps of zero cycles exercise back-to-back
      for (int i = 0; i < 40; i++) begin
         wait_idle();
         issue(1'($urandom_range(0, 1)), W'($urandom), W'($urandom), c0);
         gap = $urandom_range(0, 3);
         if (gap == 0) begin
            repeat (W) step();
         end else begin
            repeat (W + gap) step();
         end
      end
      drain();
      repeat (3) step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
      $fatal(1, "timeout");
   end

endmodule
